// File: rtl/stage_mem.sv
// Memory pipeline stage: registers execute outputs, runs the load/store on a req/ack bus,
// formats load data. Optional misalignment trap when MEM_ALIGN_CHECK_EN is defined.
module stage_mem (
    input  logic        clk,
    input  logic        rstn,
    input  logic        exn,
    input  logic        ex_bubble,
    input  logic        ex_w_rd,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_op3,
    input  logic        ex_mem_r,
    input  logic        ex_mem_w,
    input  logic [1:0]  ex_mem_sz,
    input  logic        ex_mem_sx,
    output logic        mem_stall,
    output logic        mem_w_rd,
    output logic [4:0]  mem_rd,
    output logic [31:0] mem_res,
    output logic        mem_fwd_ok,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        mem_misalign
);

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN} state_t;

    state_t      state;
    logic        valid;
    logic        w_rd;
    logic [4:0]  rd;
    logic [31:0] alu_res;
    logic        mem_r;
    logic [1:0]  lane;
    logic [1:0]  sz;
    logic        sx;
    logic [29:0] bus_word;

    logic        stage_en;
    logic        bus_en;
    logic        ex_mis;
    logic        ex_access;
    logic [3:0]  ex_be;
    logic        misalign_q;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_fmt;

    // Stage registers follow the flush even while the bus side is frozen, so a DRAIN
    // keeps presenting the killed access while the stage already holds the bubble.
    assign mem_stall = (state != IDLE) && !dbus_ack;
    assign stage_en  = !mem_stall || exn;
    assign bus_en    = !mem_stall;

`ifdef MEM_ALIGN_CHECK_EN
    assign ex_mis = ((ex_mem_sz == 2'd1) && ex_mem_addr[0]) ||
                    (ex_mem_sz[1] && (ex_mem_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            misalign_q <= 1'b0;
        end else if (stage_en) begin
            misalign_q <= !ex_bubble && !exn && (ex_mem_r || ex_mem_w) && ex_mis;
        end
    end
`else
    assign ex_mis     = 1'b0;
    assign misalign_q = 1'b0;
`endif

    assign ex_access = !ex_bubble && !exn && (ex_mem_r || ex_mem_w) && !ex_mis;

    always_comb begin
        ex_be = 4'hF;
        case (ex_mem_sz)
            2'd0:    ex_be = 4'b0001 << ex_mem_addr[1:0];
            2'd1:    ex_be = 4'b0011 << {ex_mem_addr[1], 1'b0};
            default: ex_be = 4'hF;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            valid      <= 1'b0;
            w_rd       <= 1'b0;
            rd         <= '0;
            alu_res    <= '0;
            mem_r      <= 1'b0;
            lane       <= '0;
            sz         <= '0;
            sx         <= 1'b0;
            bus_word   <= '0;
            dbus_we    <= 1'b0;
            dbus_wdata <= '0;
            dbus_be    <= '0;
        end else begin
            if (stage_en) begin
                valid   <= !ex_bubble && !exn;
                w_rd    <= ex_w_rd;
                rd      <= ex_rd;
                alu_res <= ex_alu_res;
                mem_r   <= ex_mem_r;
                lane    <= ex_mem_addr[1:0];
                sz      <= ex_mem_sz;
                sx      <= ex_mem_sx;
            end
            if (bus_en) begin
                state      <= ex_access ? ACCESS : IDLE;
                bus_word   <= ex_mem_addr[31:2];
                dbus_we    <= ex_mem_w;
                dbus_wdata <= ex_op3;
                dbus_be    <= ex_be;
            end else if (exn && state == ACCESS) begin
                state <= DRAIN;
            end
        end
    end

    always_comb begin
        byte_v   = dbus_rdata[{lane, 3'b000} +: 8];
        half_v   = dbus_rdata[{lane[1], 4'b0000} +: 16];
        load_fmt = dbus_rdata;
        case (sz)
            2'd0:    load_fmt = {{24{sx & byte_v[7]}}, byte_v};
            2'd1:    load_fmt = {{16{sx & half_v[15]}}, half_v};
            default: load_fmt = dbus_rdata;
        endcase
    end

    assign dbus_req     = (state != IDLE);
    assign dbus_addr    = {bus_word, 2'b00};
    assign mem_rd       = rd;
    assign mem_w_rd     = valid && w_rd && (state != DRAIN) && !misalign_q;
    assign mem_fwd_ok   = valid && ((state == IDLE) || ((state == ACCESS) && dbus_ack));
    assign mem_res      = ((state == ACCESS) && dbus_ack && mem_r) ? load_fmt : alu_res;
    assign mem_misalign = misalign_q;

endmodule
